seven_segment_decoder: RTL and testbench

Receive-side counterpart of the multiplexed 4-digit seven-segment driver: passively samples the segment lines and digit enables, qualifies each digit slot once stable, and maps each segment pattern back to a hex nibble. It publishes a coherent 4-digit snapshot once per complete scan. It sits in the oscilloscope firmware as a loopback/self-test monitor and as a front end for capturing external multiplexed displays.

---
 rtl/seven_segment_pkg.sv | 33 +++
 rtl/seven_segment_pattern_decode.sv | 22 ++
 rtl/seven_segment_decoder.sv | 151 +++++++++++++++
 tb/tb_seven_segment_decoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared digit count, segment width and ABCDEFG pattern table
package seven_segment_pkg;

  localparam int NDIG  = 4;
  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Segment patterns, bit 6 = A down to bit 0 = G
  localparam seg_t PAT_0 = 7'b1111110;
  localparam seg_t PAT_1 = 7'b0110000;
  localparam seg_t PAT_2 = 7'b1101101;
  localparam seg_t PAT_3 = 7'b1111001;
  localparam seg_t PAT_4 = 7'b0110011;
  localparam seg_t PAT_5 = 7'b1011011;
  localparam seg_t PAT_6 = 7'b1011111;
  localparam seg_t PAT_7 = 7'b1110000;
  localparam seg_t PAT_8 = 7'b1111111;
  localparam seg_t PAT_9 = 7'b1111011;
  localparam seg_t PAT_A = 7'b1110111;
  localparam seg_t PAT_B = 7'b0011111;
  localparam seg_t PAT_C = 7'b1001110;
  localparam seg_t PAT_D = 7'b0111101;
  localparam seg_t PAT_E = 7'b1001111;
  localparam seg_t PAT_F = 7'b1000111;

  // Indexed by nibble value; shared with the display driver
  localparam seg_t SEG_TABLE [16] = '{
    PAT_0, PAT_1, PAT_2, PAT_3, PAT_4, PAT_5, PAT_6, PAT_7,
    PAT_8, PAT_9, PAT_A, PAT_B, PAT_C, PAT_D, PAT_E, PAT_F
  };

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// rtl/seven_segment_pattern_decode.sv - maps a 7-bit segment pattern back to a hex nibble
module seven_segment_pattern_decode
  import seven_segment_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             match
);

  // Table patterns are unique, so at most one entry can hit
  always_comb begin
    nibble = 4'd0;
    match  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_TABLE[i]) begin
        nibble = 4'(i);
        match  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - samples a multiplexed 4-digit display and publishes full-scan snapshots
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                segA,
  input  logic                segB,
  input  logic                segC,
  input  logic                segD,
  input  logic                segE,
  input  logic                segF,
  input  logic                segG,
  input  logic [NDIG-1:0]     dsen,
  output logic [NDIG*4-1:0]   digits,
  output logic [NDIG-1:0]     digit_err,
  output logic                frame_valid,
  output logic                stale
);

  localparam int SMP_W   = NDIG + SEG_W;
  localparam int STAB_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int IDLE_RW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDLE_W  = (IDLE_RW > 20) ? IDLE_RW : 20;

  localparam logic [STAB_W-1:0] SETTLE_LAST  = STAB_W'(SETTLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_VAL  = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] TIMEOUT_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [SMP_W-1:0]  sync1, sync2, prev_sample;
  logic [STAB_W-1:0] stab_cnt;
  logic              captured;
  logic [IDLE_W-1:0] idle_cnt;

  logic [NDIG*4-1:0] shadow, shadow_nxt;
  logic [NDIG-1:0]   shadow_err, shadow_err_nxt;
  logic [NDIG-1:0]   seen, seen_nxt;

  logic              same, capture, valid_cap, frame_done, timeout_hit;
  logic [NDIG-1:0]   cap_en;
  logic [SEG_W-1:0]  cap_seg;
  logic [3:0]        dec_nibble;
  logic              dec_match;

  assign same        = (sync2 == prev_sample);
  assign capture     = same && !captured && (stab_cnt == SETTLE_LAST);
  assign cap_en      = sync2[SMP_W-1:SEG_W];
  assign cap_seg     = sync2[SEG_W-1:0];
  // Only a strictly one-hot digit enable identifies a slot
  assign valid_cap   = capture && (cap_en != '0) && ((cap_en & (cap_en - 1'b1)) == '0);
  assign frame_done  = valid_cap && (seen_nxt == '1);
  assign timeout_hit = !valid_cap && (idle_cnt == TIMEOUT_LAST);

  seven_segment_pattern_decode u_decode (
    .pattern (cap_seg),
    .nibble  (dec_nibble),
    .match   (dec_match)
  );

  // Two-flop synchronizer on all pins; the pins are asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {dsen, segA, segB, segC, segD, segE, segF, segG};
      sync2 <= sync1;
    end
  end

  // Stability counter: restarts on any sample change, capture fires once per stable run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sample <= '0;
      stab_cnt    <= '0;
      captured    <= 1'b0;
    end else begin
      prev_sample <= sync2;
      if (!same) begin
        stab_cnt <= '0;
        captured <= 1'b0;
      end else begin
        if (stab_cnt != '1) stab_cnt <= stab_cnt + 1'b1;
        if (capture) captured <= 1'b1;
      end
    end
  end

  // Shadow update for the slot being captured; unmatched patterns keep the old nibble
  always_comb begin
    shadow_nxt     = shadow;
    shadow_err_nxt = shadow_err;
    seen_nxt       = seen;
    if (valid_cap) begin
      for (int i = 0; i < NDIG; i++) begin
        if (cap_en[i]) begin
          if (dec_match) begin
            shadow_nxt[i*4 +: 4] = dec_nibble;
            shadow_err_nxt[i]    = 1'b0;
          end else begin
            shadow_err_nxt[i]    = 1'b1;
          end
        end
      end
      seen_nxt = seen | cap_en;
    end
  end

  // Frame tracking: publish shadow (including the completing capture) once all digits seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      shadow_err  <= '0;
      seen        <= '0;
      digits      <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      shadow      <= shadow_nxt;
      shadow_err  <= shadow_err_nxt;
      frame_valid <= frame_done;
      if (frame_done) begin
        digits    <= shadow_nxt;
        digit_err <= shadow_err_nxt;
        seen      <= '0;
      end else if (timeout_hit) begin
        seen      <= '0;
      end else begin
        seen      <= seen_nxt;
      end
    end
  end

  // Idle counter: a valid capture restarts it and clears stale; it parks at the timeout value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      stale    <= 1'b1;
    end else if (valid_cap) begin
      idle_cnt <= '0;
      stale    <= 1'b0;
    end else if (idle_cnt != TIMEOUT_VAL) begin
      idle_cnt <= idle_cnt + 1'b1;
      if (timeout_hit) stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb/tb_seven_segment_decoder.sv - scoreboard bench for seven_segment_decoder
module tb_seven_segment_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 32;
  localparam int DWELL   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'd0;
  logic [3:0]  dsen = 4'd0;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        stale;

  int tests = 0;
  int fails = 0;
  int frames = 0;

  // Independent copy of the ABCDEFG table, indexed by nibble
  logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic [15:0] m_shadow = 16'h0;
  logic [3:0]  m_err = 4'h0;
  logic [3:0]  m_seen = 4'h0;
  logic [19:0] exp_q [$];

  always #5 clk = ~clk;

  seven_segment_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .segA(seg[6]), .segB(seg[5]), .segC(seg[4]), .segD(seg[3]),
    .segE(seg[2]), .segF(seg[1]), .segG(seg[0]),
    .dsen(dsen), .digits(digits), .digit_err(digit_err),
    .frame_valid(frame_valid), .stale(stale)
  );

  // Scoreboard: every frame_valid pulse must match the next expected snapshot
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      logic [19:0] e;
      frames++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL frame_unexpected: got digits=%h err=%b, required no frame", digits, digit_err);
      end else begin
        e = exp_q.pop_front();
        if ({digits, digit_err} !== e) begin
          fails++;
          $display("FAIL frame_data: got digits=%h err=%b, required digits=%h err=%b",
                   digits, digit_err, e[19:4], e[3:0]);
        end
      end
    end
  end

  // Drive one slot; the model accepts it when dwell is long enough and dsen is one-hot
  task automatic set_slot(input logic [3:0] en, input logic [6:0] s, input int dwell);
    bit found;
    logic [3:0] nib;
    dsen = en;
    seg  = s;
    if (dwell >= SETTLE + 1 && $onehot(en)) begin
      found = 0;
      nib = 4'h0;
      for (int k = 0; k < 16; k++) if (s == tbl[k]) begin found = 1; nib = 4'(k); end
      for (int i = 0; i < 4; i++) begin
        if (en[i]) begin
          if (found) begin m_shadow[i*4 +: 4] = nib; m_err[i] = 1'b0; end
          else m_err[i] = 1'b1;
        end
      end
      m_seen = m_seen | en;
      if (m_seen == 4'hF) begin
        exp_q.push_back({m_shadow, m_err});
        m_seen = 4'h0;
      end
    end
  endtask

  task automatic drive_slot(input logic [3:0] en, input logic [6:0] s, input int dwell);
    set_slot(en, s, dwell);
    repeat (dwell) @(negedge clk);
  endtask

  task automatic scan(input int n0, input int n1, input int n2, input int n3);
    drive_slot(4'b0001, tbl[n0], DWELL);
    drive_slot(4'b0010, tbl[n1], DWELL);
    drive_slot(4'b0100, tbl[n2], DWELL);
    drive_slot(4'b1000, tbl[n3], DWELL);
  endtask

  // Quiet pins long enough for the timeout to clear partial frames
  task automatic flush(input string name);
    drive_slot(4'b0000, 7'h00, TIMEOUT + 8);
    m_seen = 4'h0;
    tests++;
    if (stale !== 1'b1) begin
      fails++;
      $display("FAIL %s_stale_after_idle: got %b, required 1", name, stale);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_frames: got %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({digits, digit_err, frame_valid, stale} !== {16'h0, 4'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_values: got digits=%h err=%b fv=%b stale=%b, required 0000 0000 0 1",
               digits, digit_err, frame_valid, stale);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_scan();
    int f0 = frames;
    scan(1, 2, 3, 4);
    tests++;
    if (frames - f0 !== 1) begin
      fails++;
      $display("FAIL clean_frame_count: got %0d, required 1", frames - f0);
    end
    tests++;
    if ({digits, digit_err} !== {16'h4321, 4'h0}) begin
      fails++;
      $display("FAIL clean_digits: got %h/%b, required 4321/0000", digits, digit_err);
    end
    tests++;
    if (stale !== 1'b0) begin
      fails++;
      $display("FAIL clean_stale: got %b, required 0", stale);
    end
    flush("clean");
  endtask

  task automatic test_short_dwell();
    int f0 = frames;
    drive_slot(4'b0001, tbl[6], DWELL);
    drive_slot(4'b0010, tbl[7], DWELL);
    drive_slot(4'b0100, tbl[8], SETTLE - 1);
    drive_slot(4'b1000, tbl[9], DWELL);
    repeat (4) @(negedge clk);
    tests++;
    if (frames - f0 !== 0) begin
      fails++;
      $display("FAIL short_no_frame: got %0d frames, required 0", frames - f0);
    end
    flush("short");
    f0 = frames;
    scan(10, 11, 12, 13);
    tests++;
    if (frames - f0 !== 1 || digits !== 16'hDCBA) begin
      fails++;
      $display("FAIL short_recover: got %0d frames digits=%h, required 1 frame DCBA", frames - f0, digits);
    end
    flush("short2");
  endtask

  task automatic test_unmatched();
    logic [3:0] prior = m_shadow[7:4];
    drive_slot(4'b0001, tbl[5], DWELL);
    drive_slot(4'b0010, 7'h00, DWELL);
    drive_slot(4'b0100, tbl[7], DWELL);
    drive_slot(4'b1000, tbl[8], DWELL);
    tests++;
    if (digit_err !== 4'b0010 || digits[7:4] !== prior) begin
      fails++;
      $display("FAIL unmatched: got err=%b d1=%h, required err=0010 d1=%h", digit_err, digits[7:4], prior);
    end
    flush("unmatched");
  endtask

  task automatic test_multihot();
    int f0 = frames;
    drive_slot(4'b0011, tbl[1], 20);
    scan(14, 15, 0, 1);
    tests++;
    if (frames - f0 !== 1 || digits !== 16'h10FE) begin
      fails++;
      $display("FAIL multihot: got %0d frames digits=%h, required 1 frame 10FE", frames - f0, digits);
    end
    flush("multihot");
  endtask

  task automatic test_timeout();
    int waited = 0;
    drive_slot(4'b0001, tbl[5], DWELL);
    drive_slot(4'b0010, tbl[6], DWELL);
    drive_slot(4'b0100, tbl[7], DWELL);
    set_slot(4'b1000, tbl[8], DWELL);
    while (frame_valid !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (frame_valid !== 1'b1) begin
      fails++;
      $display("FAIL timeout_frame_wait: got no frame_valid in %0d cycles, required one", waited);
    end
    repeat (TIMEOUT - 1) @(negedge clk);
    tests++;
    if (stale !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: got stale=%b at idle %0d, required 0", stale, TIMEOUT - 1);
    end
    @(negedge clk);
    tests++;
    if (stale !== 1'b1 || digits !== 16'h8765 || digit_err !== 4'h0) begin
      fails++;
      $display("FAIL timeout_rise: got stale=%b digits=%h err=%b, required 1 8765 0000", stale, digits, digit_err);
    end
    m_seen = 4'h0;
    repeat (5) @(negedge clk);
    scan(1, 2, 3, 4);
    tests++;
    if (stale !== 1'b0 || digits !== 16'h4321) begin
      fails++;
      $display("FAIL timeout_recover: got stale=%b digits=%h, required 0 4321", stale, digits);
    end
    flush("timeout");
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    drive_slot(4'b0001, tbl[9], DWELL);
    drive_slot(4'b0010, tbl[3], DWELL);
    rst_n = 1'b0;
    m_shadow = 16'h0;
    m_err = 4'h0;
    m_seen = 4'h0;
    repeat (2) @(negedge clk);
    tests++;
    if ({digits, digit_err, frame_valid, stale} !== {16'h0, 4'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL midreset_values: got digits=%h err=%b fv=%b stale=%b, required 0000 0000 0 1",
               digits, digit_err, frame_valid, stale);
    end
    rst_n = 1'b1;
    @(negedge clk);
    f0 = frames;
    scan(2, 7, 1, 8);
    repeat (4) @(negedge clk);
    tests++;
    if (frames - f0 !== 1) begin
      fails++;
      $display("FAIL midreset_frame_count: got %0d, required 1", frames - f0);
    end
    flush("midreset");
  endtask

  initial begin
    test_reset();
    test_clean_scan();
    test_short_dwell();
    test_unmatched();
    test_multihot();
    test_timeout();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
